md_ctrl: RTL
============

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter: W, default 32, operand/result width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  E-stage holds a mult/div-class instruction.
REQ-005 req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-006 rs_val  in  W  rs operand.
REQ-007 rt_val  in  W  rt operand.
REQ-008 cancel  in  1  E-stage flush (exception/interrupt) this cycle.
REQ-009 stall  out  1  freeze F/D/E this cycle.
REQ-010 rd_data  out  W  MFHI/MFLO result.
REQ-011 md_start  out  1  one-cycle start pulse to MultDiv.
REQ-012 md_op  out  2  MultDiv op, equal to req_op[1:0].
REQ-013 md_a  out  W  operand A to MultDiv.
REQ-014 md_b  out  W  operand B to MultDiv.
REQ-015 md_busy  in  1  MultDiv BUSY.
REQ-016 md_hi  in  W  MultDiv HI.
REQ-017 md_lo  in  W  MultDiv LO.
REQ-018 div0  out  1  divide-by-zero pulse; constant 0 when the guard is compiled out.

Function
REQ-019 States: IDLE, ISSUE, WAIT; architectural HI/LO registers live in md_ctrl.
- issue = IDLE & req_valid & req_op<4 & !cancel.
REQ-020 On issue: md_start=1 combinationally, md_a=rs_val, md_b=rt_val, md_op=req_op[1:0]; next state ISSUE.
REQ-021 ISSUE -> WAIT unconditionally after one cycle (covers the one-cycle lag before md_busy rises).
REQ-022 In WAIT with md_busy=0: HI<=md_hi, LO<=md_lo; next state IDLE.
REQ-023 stall=1 iff req_valid & state!=IDLE; this covers all eight ops, including the WAIT capture cycle.
REQ-024 In IDLE, MTHI/MTLO write rs_val into HI/LO at the next edge, unless cancel is asserted.
REQ-025 rd_data=HI for MFHI, LO for MFLO (combinational, valid only when stall=0); 0 otherwise.
REQ-026 cancel suppresses only a same-cycle issue or MT write; an in-flight operation always completes and commits.
REQ-027 md_start shall never assert outside IDLE; back-to-back ops are separated by at least 3 cycles.
REQ-028 A new request arriving in the WAIT capture cycle is stalled and issues on the following IDLE cycle.

Reset
REQ-029 reset forces, immediately: state=IDLE, HI=0, LO=0, md_start=0, stall=0, div0=0.
REQ-030 reset mid-WAIT discards the pending result; md_ctrl ignores md_busy until the next issue.

Configuration
REQ-031 With MD_CTRL_DIV0_GUARD_EN defined, DIV/DIVU with rt_val=0 behave as follows:
- md_start is suppressed;
- HI/LO are unchanged;
- div0 pulses 1 cycle;
- state stays IDLE.
REQ-032 Without MD_CTRL_DIV0_GUARD_EN, divide-by-zero issues normally and div0 is tied to 0.

Structure
REQ-033 Package md_pkg holds the req_op encoding constants and the state encoding.
REQ-034 HI/LO storage shall be the sub-module md_hilo: a register pair with two write ports, commit and MT, where commit and MT cannot coincide.

Verification
REQ-035 MULT 0x7fffffff x 0xffffffff -> one md_start pulse, then HI=0xffffffff, LO=0x80000001 after md_busy falls.
REQ-036 MULTU 0xffffffff x 2 -> HI=0x00000001, LO=0xfffffffe.
REQ-037 DIV -7 / 2, then MFLO during busy -> stall held until the cycle after commit; rd_data=0xfffffffd; HI=0xffffffff.
REQ-038 MULT with cancel=1 in the same cycle -> md_start=0, state IDLE, HI/LO unchanged.
REQ-039 MTHI 0x12345678, then MFHI -> rd_data=0x12345678 with no stall.
REQ-040 Edge cases:
- reset asserted in WAIT -> IDLE and HI=LO=0 immediately;
- with MD_CTRL_DIV0_GUARD_EN, DIVU x/0 -> div0 pulse and no md_start.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the mult/div control slice.
// Holds the req_op opcode values and the controller state type.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } md_state_e;

    // true for DIV and DIVU
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_hilo.sv
// md_hilo: architectural HI/LO register pair.
// Commit port (MultDiv result) and MT port (MTHI/MTLO) never coincide.
module md_hilo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         commit_en,
    input  logic [W-1:0] commit_hi,
    input  logic [W-1:0] commit_lo,
    input  logic         mt_hi_en,
    input  logic         mt_lo_en,
    input  logic [W-1:0] mt_data,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    // HI/LO storage; commit has priority though both are never active together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit_en) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (mt_hi_en) hi <= mt_data;
            if (mt_lo_en) lo <= mt_data;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: issues mult/div ops to MultDiv, stalls the pipe, owns HI/LO.
// Optional divide-by-zero guard: define MD_CTRL_DIV0_GUARD_EN.
module md_ctrl
    import md_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         cancel,
    output logic         stall,
    output logic [W-1:0] rd_data,
    output logic         md_start,
    output logic [1:0]   md_op,
    output logic [W-1:0] md_a,
    output logic [W-1:0] md_b,
    input  logic         md_busy,
    input  logic [W-1:0] md_hi,
    input  logic [W-1:0] md_lo,
    output logic         div0
);

    md_state_e    state;
    logic         idle;
    logic         live;
    logic         dz;
    logic         issue;
    logic         commit;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    assign idle = (state == S_IDLE);
    assign live = idle & req_valid & ~cancel & ~reset;

`ifdef MD_CTRL_DIV0_GUARD_EN
    assign dz = live & is_div(req_op) & (rt_val == '0);
`else
    assign dz = 1'b0;
`endif

    assign issue    = live & ~req_op[2] & ~dz;
    assign commit   = (state == S_WAIT) & ~md_busy;
    assign md_start = issue;
    assign md_op    = req_op[1:0];
    assign md_a     = rs_val;
    assign md_b     = rt_val;
    assign stall    = req_valid & ~idle & ~reset;
    assign div0     = dz;

    // controller FSM: IDLE -> ISSUE -> WAIT -> IDLE once MultDiv drops busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (issue) state <= S_ISSUE;
                S_ISSUE: state <= S_WAIT;
                S_WAIT:  if (!md_busy) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    md_hilo #(.W(W)) u_hilo (
        .clk       (clk),
        .reset     (reset),
        .commit_en (commit),
        .commit_hi (md_hi),
        .commit_lo (md_lo),
        .mt_hi_en  (live & (req_op == OP_MTHI)),
        .mt_lo_en  (live & (req_op == OP_MTLO)),
        .mt_data   (rs_val),
        .hi        (hi),
        .lo        (lo)
    );

    // MFHI/MFLO read mux, zero for every other request
    always_comb begin
        rd_data = '0;
        if (req_valid && req_op == OP_MFHI) rd_data = hi;
        else if (req_valid && req_op == OP_MFLO) rd_data = lo;
    end

endmodule
